output_argmax_tracker: RTL and testbench
========================================

Name: output_argmax_tracker

Overview:
- Streaming classifier back-end for the output layer.
- Consumes ZBYFI output activations per valid beat over NOUT/ZBYFI beats. Produces the argmax neuron (index, one-hot, max value) and compares it against the ideal one-hot answer streamed alongside.
- Keeps running total/correct classification counters for on-chip accuracy measurement.
- Replaces the fixed-timing inline max-act logic in the top level. Uses a valid handshake, so it is decoupled from cycle_index and ec.

Parameters:
- WIDTH, 12, activation bit width (signed two's complement)
- ZBYFI, 1, output neurons presented per beat; power of 2
- NOUT, 64, total output neurons; multiple of ZBYFI
- CNTW, 16, width of statistics counters
- Derived localparams: BEATS = NOUT/ZBYFI; IDXW = max(1, $clog2(NOUT))

Ports:
- clk, in, 1, clock
- reset, in, 1, asynchronous, active-low reset
- in_valid, in, 1, act_in/ans_in carry a beat this cycle
- act_in, in, WIDTH x ZBYFI (signed), activations of neurons beat*ZBYFI+i
- ans_in, in, ZBYFI, ideal one-hot slice for the same neurons
- clear_stats, in, 1, synchronous clear of counters
- out_valid, out, 1, one-cycle pulse: new result available
- out_idx, out, IDXW, argmax neuron index
- out_onehot, out, NOUT, 1<<out_idx
- out_max, out, WIDTH (signed), winning activation
- out_correct, out, 1, out_idx equals ideal index
- total_cnt, out, CNTW, samples classified
- correct_cnt, out, CNTW, samples classified correctly

Behaviour:
- Reset (reset low, async): all outputs 0, internal state 0. out_onehot=0 while reset is held; afterwards it tracks 1<<out_idx.
- Beat counter, 0..BEATS-1:
  - Advances only on in_valid; in_valid low is a bubble and holds all state.
  - Wraps to 0 after beat BEATS-1.
- Local max per beat: combinational over ZBYFI lanes. Ties go to the lowest lane. Position = {beat, lane} (lane omitted when ZBYFI=1).
- Running max:
  - On beat 0, loaded unconditionally with the local max, with no compare against stale state. An all-most-negative sample therefore yields idx 0.
  - On later beats, replaced only if local > running (signed, strict). Ties keep the earlier index.
- Ideal index: the lowest set ans_in bit across the sample. If no bit is set in the whole sample, out_correct=0.
- Result timing: the cycle after the valid beat BEATS-1, out_valid=1 for exactly one cycle.
  - out_idx/out_onehot/out_max/out_correct are registered and held until the next result.
  - Latency is 1 cycle from the last valid beat, independent of bubbles.
- Counters:
  - On the out_valid cycle, total_cnt+=1 and correct_cnt+=out_correct.
  - Both saturate at 2^CNTW-1 independently.
- clear_stats: zeroes both counters. If it coincides with an out_valid update, clear wins and that sample is not counted. It does not affect the beat counter or result registers.
- Reset mid-sample: partial sample discarded; next valid beat is beat 0; no out_valid is produced.
- Elaboration $error if NOUT%ZBYFI!=0 or ZBYFI is not a power of 2.

Optional Feature:
- Macro ARGMAX_TOP2_EN.
- Defined:
  - Also tracks the runner-up (same strict-greater/lowest-index rules; a value displaced from first becomes second).
  - Adds ports out_idx2 (IDXW) and top2_cnt (CNTW, saturating; counts samples whose ideal index equals out_idx or out_idx2).
  - The local stage returns the top-2 per beat.
  - For NOUT=1, out_idx2=0.
- Undefined: those ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Package dnn_out_pkg:
  - typedef struct score_t {logic signed [WIDTH-1:0] val; logic [IDXW-1:0] idx;}, parametrised via a package function or per-instance localparam types
  - function beats(NOUT, ZBYFI)
  - function sat_inc(cnt, en)
- One sub-module, argmax_tree: combinational log2(ZBYFI)-level compare tree returning score_t (top-2 under ARGMAX_TOP2_EN), lowest-index tie break.

Test Plan (NOUT=8, ZBYFI=2, WIDTH=12 unless stated):
- Basic win: neuron 5=0x1A0, all others 0x010, ans bit 5 → out_valid 1 cycle after beat 3; out_idx=5, out_onehot=0x20, out_max=0x1A0, out_correct=1, total_cnt=1, correct_cnt=1.
- Tie: neurons 2 and 6=0x100, others 0x000, ans bit 6 → out_idx=2, out_correct=0, correct_cnt unchanged.
- All 0x800 (most negative), ans all zero → out_idx=0, out_max=0x800, out_correct=0; a prior sample's larger max must not leak.
- Bubbles: in_valid low 3 cycles between beats 1 and 2 → same result as the no-bubble run; out_valid exactly 1 cycle after the final valid beat; no spurious pulses.
- Control:
  - clear_stats asserted on the out_valid cycle → total_cnt=correct_cnt=0.
  - reset pulsed low after beat 2 → outputs 0; the next 4 beats produce a correct new result.
- Saturation, CNTW=2: 5 correct samples → total_cnt=3, correct_cnt=3.
- With ARGMAX_TOP2_EN: values 0x300@1 and 0x200@4, ans bit 4 → out_idx2=4, top2_cnt=1.

Source files
------------

// File: rtl/output_argmax_tracker_pkg.sv
// Shared helpers for the output-layer argmax tracker: beat count, index widths
// and a saturating counter increment.
package dnn_out_pkg;

  function automatic int beats(input int nout, input int zbyfi);
    return nout / zbyfi;
  endfunction

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en,
                                          input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (en && (cnt < max_v)) return cnt + 32'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/output_argmax_tracker_argmax_tree.sv
// Combinational compare tree over the ZBYFI lanes of one beat; ties resolve to
// the lowest lane. With ARGMAX_TOP2_EN it also returns the runner-up lane.
module argmax_tree
  import dnn_out_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int ZBYFI = 1,
  parameter int LANEW = idx_w(ZBYFI)
) (
  input  logic [ZBYFI*WIDTH-1:0] act_i,
  output logic [WIDTH-1:0]       best_val_o,
  output logic [LANEW-1:0]       best_lane_o
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [WIDTH-1:0]       second_val_o,
  output logic [LANEW-1:0]       second_lane_o,
  output logic                   second_vld_o
`endif
);

  localparam int LEVELS = $clog2(ZBYFI);

  typedef struct packed {
    logic signed [WIDTH-1:0] val;
    logic [LANEW-1:0]        idx;
`ifdef ARGMAX_TOP2_EN
    logic signed [WIDTH-1:0] val2;
    logic [LANEW-1:0]        idx2;
    logic                    has2;
`endif
  } score_t;

  // a always covers lower lanes than b, so a wins every tie.
  function automatic score_t merge(input score_t a, input score_t b);
    score_t r;
    r = a;
    if ($signed(b.val) > $signed(a.val)) begin
      r.val = b.val;
      r.idx = b.idx;
`ifdef ARGMAX_TOP2_EN
      if (b.has2 && ($signed(b.val2) > $signed(a.val))) begin
        r.val2 = b.val2;
        r.idx2 = b.idx2;
      end else begin
        r.val2 = a.val;
        r.idx2 = a.idx;
      end
`endif
    end
`ifdef ARGMAX_TOP2_EN
    else if (!(a.has2 && ($signed(a.val2) >= $signed(b.val)))) begin
      r.val2 = b.val;
      r.idx2 = b.idx;
    end
    r.has2 = 1'b1;
`endif
    return r;
  endfunction

  score_t root;

  // In-place pairwise reduction: level l folds entries 2i/2i+1 into entry i.
  always_comb begin
    score_t tmp [ZBYFI];
    for (int i = 0; i < ZBYFI; i++) begin
      tmp[i]     = '0;
      tmp[i].val = act_i[i*WIDTH +: WIDTH];
      tmp[i].idx = LANEW'(i);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < (ZBYFI >> (l + 1)); i++) begin
        tmp[i] = merge(tmp[2*i], tmp[2*i+1]);
      end
    end
    root = tmp[0];
  end

  assign best_val_o  = root.val;
  assign best_lane_o = root.idx;
`ifdef ARGMAX_TOP2_EN
  assign second_val_o  = root.val2;
  assign second_lane_o = root.idx2;
  assign second_vld_o  = root.has2;
`endif

endmodule

// File: rtl/output_argmax_tracker.sv
// Streaming argmax over NOUT output activations (ZBYFI per valid beat) with
// accuracy counters. Define ARGMAX_TOP2_EN to add runner-up tracking.
module output_argmax_tracker
  import dnn_out_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int ZBYFI  = 1,
  parameter int NOUT   = 64,
  parameter int CNTW   = 16,
  localparam int BEATS = beats(NOUT, ZBYFI),
  localparam int IDXW  = idx_w(NOUT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [ZBYFI*WIDTH-1:0] act_in,
  input  logic [ZBYFI-1:0]       ans_in,
  input  logic                   clear_stats,
  output logic                   out_valid,
  output logic [IDXW-1:0]        out_idx,
  output logic [NOUT-1:0]        out_onehot,
  output logic signed [WIDTH-1:0] out_max,
  output logic                   out_correct,
  output logic [CNTW-1:0]        total_cnt,
  output logic [CNTW-1:0]        correct_cnt
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IDXW-1:0]        out_idx2,
  output logic [CNTW-1:0]        top2_cnt
`endif
);

  localparam int LANEW = idx_w(ZBYFI);
  localparam int BEATW = idx_w(BEATS);
  localparam logic [NOUT-1:0] ONE_HOT0 = NOUT'(1);

  if ((NOUT % ZBYFI) != 0) begin : g_bad_nout
    $error("output_argmax_tracker: NOUT must be a multiple of ZBYFI");
  end
  if ((ZBYFI < 1) || ((ZBYFI & (ZBYFI - 1)) != 0)) begin : g_bad_zbyfi
    $error("output_argmax_tracker: ZBYFI must be a power of 2");
  end

  typedef struct packed {
    logic signed [WIDTH-1:0] val;
    logic [IDXW-1:0]         idx;
`ifdef ARGMAX_TOP2_EN
    logic signed [WIDTH-1:0] val2;
    logic [IDXW-1:0]         idx2;
    logic                    has2;
`endif
  } score_t;

  // Running state always holds lower neuron indices than the incoming beat.
  function automatic score_t merge(input score_t a, input score_t b);
    score_t r;
    r = a;
    if ($signed(b.val) > $signed(a.val)) begin
      r.val = b.val;
      r.idx = b.idx;
`ifdef ARGMAX_TOP2_EN
      if (b.has2 && ($signed(b.val2) > $signed(a.val))) begin
        r.val2 = b.val2;
        r.idx2 = b.idx2;
      end else begin
        r.val2 = a.val;
        r.idx2 = a.idx;
      end
`endif
    end
`ifdef ARGMAX_TOP2_EN
    else if (!(a.has2 && ($signed(a.val2) >= $signed(b.val)))) begin
      r.val2 = b.val;
      r.idx2 = b.idx;
    end
    r.has2 = 1'b1;
`endif
    return r;
  endfunction

  logic [WIDTH-1:0] tree_val;
  logic [LANEW-1:0] tree_lane;
`ifdef ARGMAX_TOP2_EN
  logic [WIDTH-1:0] tree_val2;
  logic [LANEW-1:0] tree_lane2;
  logic             tree_has2;
`endif

  argmax_tree #(.WIDTH(WIDTH), .ZBYFI(ZBYFI), .LANEW(LANEW)) u_tree (
    .act_i        (act_in),
    .best_val_o   (tree_val),
    .best_lane_o  (tree_lane)
`ifdef ARGMAX_TOP2_EN
    ,
    .second_val_o (tree_val2),
    .second_lane_o(tree_lane2),
    .second_vld_o (tree_has2)
`endif
  );

  logic [BEATW-1:0] beat_q, beat_d;
  score_t           run_q, run_d, loc, fin;
  logic             ideal_found_q, ideal_found_d, ideal_found_fin, beat_found;
  logic [IDXW-1:0]  ideal_idx_q, ideal_idx_d, ideal_idx_fin, beat_ideal;
  logic [LANEW-1:0] beat_lane;
  logic             last_beat;

  logic             out_valid_q, out_valid_d;
  logic [IDXW-1:0]  out_idx_q, out_idx_d;
  logic [WIDTH-1:0] out_max_q, out_max_d;
  logic             out_correct_q, out_correct_d;
  logic [CNTW-1:0]  total_q, total_d, correct_q, correct_d;
  logic [31:0]      total_inc, correct_inc;
`ifdef ARGMAX_TOP2_EN
  logic [IDXW-1:0]  out_idx2_q, out_idx2_d;
  logic             out_top2_q, out_top2_d;
  logic [CNTW-1:0]  top2_q, top2_d;
  logic [31:0]      top2_inc;
`endif

  // Neuron position of a lane in the current beat is beat*ZBYFI + lane.
  always_comb begin
    loc     = '0;
    loc.val = tree_val;
    loc.idx = IDXW'(int'(beat_q) * ZBYFI + int'(tree_lane));
`ifdef ARGMAX_TOP2_EN
    loc.val2 = tree_val2;
    loc.idx2 = IDXW'(int'(beat_q) * ZBYFI + int'(tree_lane2));
    loc.has2 = tree_has2;
`endif
    beat_found = 1'b0;
    beat_lane  = '0;
    for (int i = ZBYFI - 1; i >= 0; i--) begin
      if (ans_in[i]) begin
        beat_found = 1'b1;
        beat_lane  = LANEW'(i);
      end
    end
    beat_ideal = IDXW'(int'(beat_q) * ZBYFI + int'(beat_lane));
  end

  // Beat 0 reloads from the local result so nothing from the previous sample leaks.
  always_comb begin
    last_beat = (beat_q == BEATW'(BEATS - 1));
    if (beat_q == '0) begin
      fin             = loc;
      ideal_found_fin = beat_found;
      ideal_idx_fin   = beat_ideal;
    end else begin
      fin             = merge(run_q, loc);
      ideal_found_fin = ideal_found_q || beat_found;
      ideal_idx_fin   = ideal_found_q ? ideal_idx_q : beat_ideal;
    end
  end

  always_comb begin
    beat_d        = beat_q;
    run_d         = run_q;
    ideal_found_d = ideal_found_q;
    ideal_idx_d   = ideal_idx_q;
    out_valid_d   = 1'b0;
    out_idx_d     = out_idx_q;
    out_max_d     = out_max_q;
    out_correct_d = out_correct_q;
`ifdef ARGMAX_TOP2_EN
    out_idx2_d    = out_idx2_q;
    out_top2_d    = out_top2_q;
`endif
    if (in_valid) begin
      beat_d        = last_beat ? '0 : beat_q + BEATW'(1);
      run_d         = fin;
      ideal_found_d = ideal_found_fin;
      ideal_idx_d   = ideal_idx_fin;
      if (last_beat) begin
        out_valid_d   = 1'b1;
        out_idx_d     = fin.idx;
        out_max_d     = fin.val;
        out_correct_d = ideal_found_fin && (ideal_idx_fin == fin.idx);
`ifdef ARGMAX_TOP2_EN
        out_idx2_d    = fin.has2 ? fin.idx2 : '0;
        out_top2_d    = ideal_found_fin && ((ideal_idx_fin == fin.idx) ||
                        (fin.has2 && (ideal_idx_fin == fin.idx2)));
`endif
      end
    end
  end

  // Statistics follow the registered result; a coincident clear discards it.
  always_comb begin
    total_inc   = sat_inc(32'(total_q), 1'b1, CNTW);
    correct_inc = sat_inc(32'(correct_q), out_correct_q, CNTW);
    total_d     = total_q;
    correct_d   = correct_q;
`ifdef ARGMAX_TOP2_EN
    top2_inc    = sat_inc(32'(top2_q), out_top2_q, CNTW);
    top2_d      = top2_q;
`endif
    if (clear_stats) begin
      total_d   = '0;
      correct_d = '0;
`ifdef ARGMAX_TOP2_EN
      top2_d    = '0;
`endif
    end else if (out_valid_q) begin
      total_d   = total_inc[CNTW-1:0];
      correct_d = correct_inc[CNTW-1:0];
`ifdef ARGMAX_TOP2_EN
      top2_d    = top2_inc[CNTW-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q        <= '0;
      run_q         <= '0;
      ideal_found_q <= 1'b0;
      ideal_idx_q   <= '0;
      out_valid_q   <= 1'b0;
      out_idx_q     <= '0;
      out_max_q     <= '0;
      out_correct_q <= 1'b0;
      total_q       <= '0;
      correct_q     <= '0;
`ifdef ARGMAX_TOP2_EN
      out_idx2_q    <= '0;
      out_top2_q    <= 1'b0;
      top2_q        <= '0;
`endif
    end else begin
      beat_q        <= beat_d;
      run_q         <= run_d;
      ideal_found_q <= ideal_found_d;
      ideal_idx_q   <= ideal_idx_d;
      out_valid_q   <= out_valid_d;
      out_idx_q     <= out_idx_d;
      out_max_q     <= out_max_d;
      out_correct_q <= out_correct_d;
      total_q       <= total_d;
      correct_q     <= correct_d;
`ifdef ARGMAX_TOP2_EN
      out_idx2_q    <= out_idx2_d;
      out_top2_q    <= out_top2_d;
      top2_q        <= top2_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign out_onehot  = reset ? (ONE_HOT0 << out_idx_q) : '0;
  assign out_max     = out_max_q;
  assign out_correct = out_correct_q;
  assign total_cnt   = total_q;
  assign correct_cnt = correct_q;
`ifdef ARGMAX_TOP2_EN
  assign out_idx2    = out_idx2_q;
  assign top2_cnt    = top2_q;
`endif

endmodule

// File: tb/tb_output_argmax_tracker.sv
// Scoreboard bench for output_argmax_tracker (NOUT=8, ZBYFI=2, WIDTH=12) with a
// second CNTW=2 instance sharing the stimulus for counter saturation.
module tb_output_argmax_tracker;

  localparam int WIDTH = 12;
  localparam int ZBYFI = 2;
  localparam int NOUT  = 8;
  localparam int BEATS = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   clear_stats = 1'b0;
  logic [ZBYFI*WIDTH-1:0] act_in = '0;
  logic [ZBYFI-1:0]       ans_in = '0;

  logic        out_valid, out_correct;
  logic [2:0]  out_idx;
  logic [7:0]  out_onehot;
  logic [11:0] out_max;
  logic [15:0] total_cnt, correct_cnt;
  logic        s_out_valid, s_out_correct;
  logic [2:0]  s_out_idx;
  logic [7:0]  s_out_onehot;
  logic [11:0] s_out_max;
  logic [1:0]  s_total_cnt, s_correct_cnt;
`ifdef ARGMAX_TOP2_EN
  logic [2:0]  out_idx2, s_out_idx2;
  logic [15:0] top2_cnt;
  logic [1:0]  s_top2_cnt;
`endif

  output_argmax_tracker #(.WIDTH(WIDTH), .ZBYFI(ZBYFI), .NOUT(NOUT), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .act_in(act_in), .ans_in(ans_in),
    .clear_stats(clear_stats), .out_valid(out_valid), .out_idx(out_idx),
    .out_onehot(out_onehot), .out_max(out_max), .out_correct(out_correct),
    .total_cnt(total_cnt), .correct_cnt(correct_cnt)
`ifdef ARGMAX_TOP2_EN
    , .out_idx2(out_idx2), .top2_cnt(top2_cnt)
`endif
  );

  output_argmax_tracker #(.WIDTH(WIDTH), .ZBYFI(ZBYFI), .NOUT(NOUT), .CNTW(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .act_in(act_in), .ans_in(ans_in),
    .clear_stats(clear_stats), .out_valid(s_out_valid), .out_idx(s_out_idx),
    .out_onehot(s_out_onehot), .out_max(s_out_max), .out_correct(s_out_correct),
    .total_cnt(s_total_cnt), .correct_cnt(s_correct_cnt)
`ifdef ARGMAX_TOP2_EN
    , .out_idx2(s_out_idx2), .top2_cnt(s_top2_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_valid_now = 1'b0;

  // {top2_hit, idx2[2:0], idx[2:0], max[11:0], correct}
  logic [19:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] ex(input logic [2:0] idx, input logic [11:0] mx,
                                     input logic corr, input logic [2:0] idx2,
                                     input logic t2);
    return {t2, idx2, idx, mx, corr};
  endfunction

  // Neuron k occupies bits [k*12 +: 12]; k = -1 means unused override.
  function automatic logic [95:0] mk(input logic [11:0] dflt,
                                     input int k1, input logic [11:0] v1,
                                     input int k2, input logic [11:0] v2,
                                     input int k3, input logic [11:0] v3);
    logic [95:0] r;
    for (int k = 0; k < 8; k++) r[k*12 +: 12] = dflt;
    if (k1 >= 0) r[k1*12 +: 12] = v1;
    if (k2 >= 0) r[k2*12 +: 12] = v2;
    if (k3 >= 0) r[k3*12 +: 12] = v3;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_beats(input logic [95:0] acts, input logic [7:0] ans,
                             input int nbeats, input int bub_at, input int bub_len);
    for (int b = 0; b < nbeats; b++) begin
      if (b == bub_at) begin
        repeat (bub_len) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
          act_in   = 24'($urandom);
          ans_in   = 2'($urandom_range(0, 3));
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      act_in   = acts[b*24 +: 24];
      ans_in   = ans[b*2 +: 2];
    end
  endtask

  task automatic send_sample(input logic [95:0] acts, input logic [7:0] ans,
                             input logic [19:0] exp, input int bub_at,
                             input int bub_len, input logic clr);
    exp_q.push_back(exp);
    drive_beats(acts, ans, BEATS, bub_at, bub_len);
    @(posedge clk); #1;
    in_valid      = 1'b0;
    act_in        = '0;
    ans_in        = '0;
    exp_valid_now = 1'b1;
    clear_stats   = clr;
    @(posedge clk); #1;
    exp_valid_now = 1'b0;
    clear_stats   = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  int   m_tot = 0, m_cor = 0, m_t2 = 0, s_tot = 0, s_cor = 0, s_t2 = 0;
  logic pend = 1'b0;

  initial begin
    logic [19:0] e;
    logic        got_e;
    forever begin
      @(negedge clk);
      got_e = 1'b0;
      e     = '0;
      if (!reset) begin
        m_tot = 0; m_cor = 0; m_t2 = 0; s_tot = 0; s_cor = 0; s_t2 = 0;
        pend  = 1'b0;
      end else begin
        if (pend) begin
          chk("total_cnt", 32'(total_cnt), m_tot);
          chk("correct_cnt", 32'(correct_cnt), m_cor);
          chk("sat_total_cnt", 32'(s_total_cnt), s_tot);
          chk("sat_correct_cnt", 32'(s_correct_cnt), s_cor);
`ifdef ARGMAX_TOP2_EN
          chk("top2_cnt", 32'(top2_cnt), m_t2);
          chk("sat_top2_cnt", 32'(s_top2_cnt), s_t2);
`endif
          pend = 1'b0;
        end
        if (out_valid || exp_valid_now) chk("out_valid", 32'(out_valid), 32'(exp_valid_now));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: out_valid=1 with no expected sample (t=%0t)", $time);
          end else begin
            e     = exp_q.pop_front();
            got_e = 1'b1;
            chk("out_idx", 32'(out_idx), 32'(e[15:13]));
            chk("out_onehot", 32'(out_onehot), 32'(8'd1 << e[15:13]));
            chk("out_max", 32'(out_max), 32'(e[12:1]));
            chk("out_correct", 32'(out_correct), 32'(e[0]));
            chk("sat_out_idx", 32'(s_out_idx), 32'(e[15:13]));
`ifdef ARGMAX_TOP2_EN
            chk("out_idx2", 32'(out_idx2), 32'(e[18:16]));
`endif
          end
        end
        if (clear_stats) begin
          m_tot = 0; m_cor = 0; m_t2 = 0; s_tot = 0; s_cor = 0; s_t2 = 0;
        end else if (got_e) begin
          if (m_tot < 65535) m_tot++;
          if (e[0] && m_cor < 65535) m_cor++;
          if (e[19] && m_t2 < 65535) m_t2++;
          if (s_tot < 3) s_tot++;
          if (e[0] && s_cor < 3) s_cor++;
          if (e[19] && s_t2 < 3) s_t2++;
        end
        pend = out_valid;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: bench did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_onehot", 32'(out_onehot), 0);
    chk("rst_out_max", 32'(out_max), 0);
    chk("rst_out_correct", 32'(out_correct), 0);
    chk("rst_total_cnt", 32'(total_cnt), 0);
    chk("rst_correct_cnt", 32'(correct_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    chk("onehot_after_reset", 32'(out_onehot), 32'h01);

    // basic win at neuron 5
    send_sample(mk(12'h010, 5, 12'h1A0, -1, 0, -1, 0), 8'h20,
                ex(3'd5, 12'h1A0, 1'b1, 3'd0, 1'b1), -1, 0, 1'b0);
    // tie between 2 and 6: earlier index wins, ideal is 6
    send_sample(mk(12'h000, 2, 12'h100, 6, 12'h100, -1, 0), 8'h40,
                ex(3'd2, 12'h100, 1'b0, 3'd6, 1'b1), -1, 0, 1'b0);
    // all most-negative, no ideal bit
    send_sample(mk(12'h800, -1, 0, -1, 0, -1, 0), 8'h00,
                ex(3'd0, 12'h800, 1'b0, 3'd1, 1'b0), -1, 0, 1'b0);
    // basic again with a 3-cycle bubble between beats 1 and 2
    send_sample(mk(12'h010, 5, 12'h1A0, -1, 0, -1, 0), 8'h20,
                ex(3'd5, 12'h1A0, 1'b1, 3'd0, 1'b1), 2, 3, 1'b0);
    // signed compare and cross-beat tie at max positive
    send_sample(mk(12'h800, 0, 12'hFFF, 3, 12'h7FF, 4, 12'h7FF), 8'h08,
                ex(3'd3, 12'h7FF, 1'b1, 3'd4, 1'b1), -1, 0, 1'b0);
    // clear_stats on the out_valid cycle
    send_sample(mk(12'hFF0, 1, 12'h005, -1, 0, -1, 0), 8'h02,
                ex(3'd1, 12'h005, 1'b1, 3'd0, 1'b1), -1, 0, 1'b1);

    // reset after beat 2 of a partial sample
    drive_beats(mk(12'h000, 5, 12'h3FF, -1, 0, -1, 0), 8'h20, 3, -1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_idx", 32'(out_idx), 0);
    chk("midrst_out_onehot", 32'(out_onehot), 0);
    chk("midrst_out_max", 32'(out_max), 0);
    chk("midrst_out_correct", 32'(out_correct), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    send_sample(mk(12'h040, 6, 12'h050, -1, 0, -1, 0), 8'h40,
                ex(3'd6, 12'h050, 1'b1, 3'd0, 1'b1), -1, 0, 1'b0);
    // two ideal bits: lowest one (2) counts
    send_sample(mk(12'h000, 2, 12'h123, -1, 0, -1, 0), 8'h24,
                ex(3'd2, 12'h123, 1'b1, 3'd0, 1'b1), -1, 0, 1'b0);
    send_sample(mk(12'h000, 7, 12'h001, -1, 0, -1, 0), 8'h80,
                ex(3'd7, 12'h001, 1'b1, 3'd0, 1'b1), -1, 0, 1'b0);
    // in-beat lane tie goes to lane 0; saturates the CNTW=2 instance
    send_sample(mk(12'h000, 0, 12'h200, 1, 12'h200, -1, 0), 8'h01,
                ex(3'd0, 12'h200, 1'b1, 3'd1, 1'b1), -1, 0, 1'b0);
    // runner-up carries the ideal answer
    send_sample(mk(12'h000, 1, 12'h300, 4, 12'h200, -1, 0), 8'h10,
                ex(3'd1, 12'h300, 1'b0, 3'd4, 1'b1), -1, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
